// File: rtl/operand_net_s_pkg.sv
// operand_net_s_pkg: shared operand-network types and the default bypass buffer depth.
package pkg_tpu;
  typedef logic [31:0] data_t;
  typedef logic [4:0] index_t;
  localparam int BYPASS_BUFF_SIZE = 4;
  typedef struct packed {
    logic   valid;
    index_t index;
    data_t  data;
  } bypass_entry_t;
endpackage

// File: rtl/operand_net_s_if.sv
// operand_net_s_if: Reg-Read / writeback / operand-output bundle of the operand network.
interface operand_net_s_if #(parameter int NUM_SRC = 3);
  import pkg_tpu::*;
  localparam int WIDTH_SEL = $clog2(NUM_SRC + 1);
  logic                  I_Stall;
  logic                  I_Req;
  logic [WIDTH_SEL-1:0]  I_Sel_Path;
  logic [WIDTH_SEL-1:0]  I_Sel_Path_WB;
  data_t [NUM_SRC-1:0]   I_Src_Data;
  index_t [NUM_SRC-1:0]  I_Src_Idx;
  logic                  I_WB_Valid;
  index_t                I_WB_Index;
  data_t                 I_WB_Data;
  logic                  I_Commit;
  logic                  O_Valid;
  data_t [NUM_SRC-1:0]   O_Src_Data;
  data_t                 O_PAC_Src_Data;
  data_t                 O_WB_Data;
  logic                  O_Buff_Full;
  logic                  O_Overflow;
  modport master (
    output I_Stall, I_Req, I_Sel_Path, I_Sel_Path_WB, I_Src_Data, I_Src_Idx,
           I_WB_Valid, I_WB_Index, I_WB_Data, I_Commit,
    input  O_Valid, O_Src_Data, O_PAC_Src_Data, O_WB_Data, O_Buff_Full, O_Overflow
  );
  modport slave (
    input  I_Stall, I_Req, I_Sel_Path, I_Sel_Path_WB, I_Src_Data, I_Src_Idx,
           I_WB_Valid, I_WB_Index, I_WB_Data, I_Commit,
    output O_Valid, O_Src_Data, O_PAC_Src_Data, O_WB_Data, O_Buff_Full, O_Overflow
  );
endinterface

// File: rtl/operand_net_s_bypass_fifo.sv
// bypass_fifo_s: circular buffer of uncommitted writebacks with a per-source youngest-match lookup.
module bypass_fifo_s
  import pkg_tpu::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int BUFF_DEPTH = BYPASS_BUFF_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  index_t               push_idx,
  input  data_t                push_data,
  input  index_t [NUM_SRC-1:0] src_idx,
  output logic [NUM_SRC-1:0]   hit,
  output data_t [NUM_SRC-1:0]  hit_data,
  output logic                 full,
  output logic                 overflow
);
  localparam int PW = $clog2(BUFF_DEPTH);
  bypass_entry_t [BUFF_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, do_pop, do_push;
  assign full = cnt_q == (PW+1)'(BUFF_DEPTH);
  assign overflow = ovf_q;
  // Pop clears before push sets, so push+pop on a full buffer reuses the same slot.
  always_comb begin
    do_pop = pop && cnt_q != '0;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_pop) mem_d[rptr_q].valid = 1'b0;
    if (do_push) mem_d[wptr_q] = '{valid: 1'b1, index: push_idx, data: push_data};
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    ovf_d = ovf_q | (push & full & ~do_pop);
  end
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit = '0;
    hit_data = '0;
    for (int k = 0; k < NUM_SRC; k++)
      for (int i = BUFF_DEPTH; i >= 1; i--)
        if (mem_q[wptr_q - PW'(i)].valid && mem_q[wptr_q - PW'(i)].index == src_idx[k]) begin
          hit[k] = 1'b1;
          hit_data[k] = mem_q[wptr_q - PW'(i)].data;
        end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/operand_net_s.sv
// operand_net_s: forwards writeback/bypass values into registered operands; OPERAND_NET_S_BYPASS_EN enables forwarding.
module operand_net_s
  import pkg_tpu::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int BUFF_DEPTH = BYPASS_BUFF_SIZE,
  parameter int WIDTH_SEL  = $clog2(NUM_SRC + 1)
) (
  input logic            clock,
  input logic            reset,
  operand_net_s_if.slave bus
);
  data_t [NUM_SRC-1:0] fwd, src_q, src_d, hit_data;
  logic [NUM_SRC-1:0] hit;
  data_t pac_q, pac_d, pac_sel, wb_sel;
  logic valid_q, valid_d, wb_fwd_en, buff_full, overflow;
`ifdef OPERAND_NET_S_BYPASS_EN
  assign wb_fwd_en = bus.I_WB_Valid;
  bypass_fifo_s #(.NUM_SRC(NUM_SRC), .BUFF_DEPTH(BUFF_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.I_WB_Valid),
    .pop       (bus.I_Commit),
    .push_idx  (bus.I_WB_Index),
    .push_data (bus.I_WB_Data),
    .src_idx   (bus.I_Src_Idx),
    .hit       (hit),
    .hit_data  (hit_data),
    .full      (buff_full),
    .overflow  (overflow)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{bus.I_WB_Valid, bus.I_Commit, BUFF_DEPTH[0]};
  assign wb_fwd_en = 1'b0;
  assign hit = '0;
  assign hit_data = '0;
  assign buff_full = 1'b0;
  assign overflow = 1'b0;
`endif
  always_comb begin
    pac_sel = '0;
    wb_sel = bus.I_WB_Data;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd[k] = (wb_fwd_en && bus.I_WB_Index == bus.I_Src_Idx[k]) ? bus.I_WB_Data :
               hit[k] ? hit_data[k] : bus.I_Src_Data[k];
      if (bus.I_Sel_Path == WIDTH_SEL'(k + 1)) pac_sel = fwd[k];
      if (bus.I_Sel_Path_WB == WIDTH_SEL'(k + 1)) wb_sel = fwd[k];
    end
    valid_d = bus.I_Stall ? valid_q : bus.I_Req;
    src_d = (bus.I_Req && !bus.I_Stall) ? fwd : src_q;
    pac_d = (bus.I_Req && !bus.I_Stall) ? pac_sel : pac_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_q <= '0;
      pac_q <= '0;
    end else begin
      valid_q <= valid_d;
      src_q <= src_d;
      pac_q <= pac_d;
    end
  end
  assign bus.O_Valid = valid_q;
  assign bus.O_Src_Data = src_q;
  assign bus.O_PAC_Src_Data = pac_q;
  assign bus.O_WB_Data = wb_sel;
  assign bus.O_Buff_Full = buff_full;
  assign bus.O_Overflow = overflow;
endmodule

// File: doc/operand_net_s.md
# operand_net_s

Parametrised scalar-unit operand network: takes NUM_SRC register-file operands, forwards the youngest matching value from an internal bypass buffer of uncommitted writebacks or from the current writeback, and registers the selected operands for the execution unit. It also selects the PAC-unit operand and the writeback-path data. It sits between Reg-Read and the scalar ALU/PAC stage. It is the successor of the fixed 3-source network, generalising source count, buffer depth and path selection, and adding valid tracking, drain/commit and overflow reporting.

## Interface
- NUM_SRC, 3, number of source operands (2..4)
- BUFF_DEPTH, 4, bypass buffer entries (power of 2, ≥2)
- WIDTH_SEL, $clog2(NUM_SRC+1), path-select width; code 0 = none/ALU, k = source k
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- I_Stall  in  1  freeze output stage
- I_Req  in  1  operands valid from Reg-Read
- I_Sel_Path  in  WIDTH_SEL  PAC operand select
- I_Sel_Path_WB  in  WIDTH_SEL  writeback-data select
- I_Src_Data  in  NUM_SRC×data_t  regfile data
- I_Src_Idx  in  NUM_SRC×index_t  source register indices
- I_WB_Valid  in  1  ALU writeback valid
- I_WB_Index  in  index_t  writeback destination
- I_WB_Data  in  data_t  ALU result
- I_Commit  in  1  regfile has absorbed oldest buffer entry; pop it
- O_Valid  out  1  output operands valid
- O_Src_Data  out  NUM_SRC×data_t  forwarded operands
- O_PAC_Src_Data  out  data_t  PAC operand, registered
- O_WB_Data  out  data_t  writeback data, combinational
- O_Buff_Full  out  1  buffer holds BUFF_DEPTH entries
- O_Overflow  out  1  sticky: push dropped while full

## Operation
- Buffer: circular FIFO of {index, data}; write pointer, read pointer, count of $clog2(BUFF_DEPTH)+1 bits; pointers wrap modulo BUFF_DEPTH.
- Push when I_WB_Valid. Pop when I_Commit and count>0. Commit on empty is ignored.
- Simultaneous push and pop: both happen, count unchanged. This is legal when full.
- Push while full without a pop: entry dropped, O_Overflow set until reset.
- Forwarding per source k, in priority order:
  - the current writeback (I_WB_Valid and I_WB_Index == I_Src_Idx[k]);
  - otherwise the youngest valid buffer entry with a matching index (search from write pointer backwards);
  - otherwise I_Src_Data[k].
- An entry popped in the same cycle is still eligible for matching.
- O_PAC_Src_Data: forwarded source I_Sel_Path when 1..NUM_SRC; 0 for code 0 or out of range.
- O_WB_Data: forwarded source I_Sel_Path_WB when 1..NUM_SRC; otherwise I_WB_Data.
- Output stage, when !I_Stall:
  - O_Valid <= I_Req;
  - O_Src_Data and O_PAC_Src_Data <= forwarded values when I_Req, else hold.
- I_Stall freezes the output stage only. Buffer push and pop continue during stall.

## Timing
- Operand latency: 1 cycle from I_Req to O_Valid and data.
- O_WB_Data: 0 cycles.
- Writeback at cycle t is visible to a request at cycle t (direct path) and to every later request (buffer) until popped.
- O_Buff_Full reflects the registered count (count == BUFF_DEPTH); it updates one cycle after the push.
- Reset values: O_Valid=0, O_Src_Data=0, O_PAC_Src_Data=0, O_Overflow=0, O_Buff_Full=0, pointers=0, count=0, all entry valid bits=0.
- Reset mid-operation discards all buffered writebacks. Reset has priority over stall, push and pop.

## Configuration
- Macro: OPERAND_NET_S_BYPASS_EN.
- Defined: buffer and forwarding as above.
- Undefined:
  - no buffer storage;
  - O_Src_Data takes I_Src_Data directly (still registered, same latency);
  - O_Buff_Full=0 and O_Overflow=0 constantly;
  - I_WB_Valid, I_WB_Index and I_Commit are ignored.

## Structure
- pkg_tpu holds data_t, index_t, BYPASS_BUFF_SIZE (default for BUFF_DEPTH) and a bypass_entry_t struct {valid, index_t index, data_t data}.
- Sub-module bypass_fifo_s: storage, pointers, count, full and overflow flags, and an NUM_SRC-port youngest-match lookup returning hit + data.
- Top level: direct-writeback priority, path selects, output register.

## Test plan
- Reset, then I_Req with Idx{1,2,3} Data{0x10,0x20,0x30} -> next cycle O_Valid=1, O_Src_Data={0x10,0x20,0x30}, O_Buff_Full=0.
- Same-cycle forward: I_WB_Valid idx 2 data 0xAA with I_Req Idx{2,5,2} -> O_Src_Data={0xAA,regfile,0xAA}.
- Youngest match: push idx 4 = 0x1 then idx 4 = 0x2, no commit, then request Idx{4,..} -> 0x2. After two commits the same request returns regfile data.
- Fill BUFF_DEPTH=4 -> O_Buff_Full=1. Fifth push without commit -> O_Overflow=1 and the dropped value is never forwarded. Push+commit while full -> count stays 4, no overflow.
- I_Stall held 3 cycles with changing inputs -> outputs frozen. Pushes during stall are forwarded on the first request after stall drops.
- I_Sel_Path=2 -> O_PAC_Src_Data equals forwarded src2. I_Sel_Path_WB=0 -> O_WB_Data=I_WB_Data. Reset with 3 entries buffered -> count 0, no forwarding afterwards.
